fifo_session_ctrl: RTL
======================

# fifo_session_ctrl

Session controller and two-port arbiter in front of the letter FIFO (16-entry, 4-bit pointers, accepts only 'A'..'Z', ends a write phase on '$'). It grants one of two requesters a complete session at a time, round-robin. For each session it sequences the FIFO handshake: start, write, terminate, then read back. It also sanitises the character stream and routes the read-back data to the granted requester.

## Interface
- MAX_LEN, default 15: maximum letters per session. Must be ≤ 15; 16 letters would wrap the FIFO write pointer onto the read pointer.
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high; also resets the FIFO
- req0, req1  in  1  session request, level
- vld0, vld1  in  1  character valid from requester i
- last0, last1  in  1  qualifies vld_i; this character ends the write phase
- char0, char1  in  8  character from requester i
- gnt0, gnt1  out  1  requester i owns the current session
- take0, take1  out  1  requester i may present characters this cycle (WRITE state and gnt_i)
- rd_data  out  8  read-back character; people_thing_out in READ, else 8'h00
- rd_vld0, rd_vld1  out  1  rd_data is valid for requester i
- done0, done1  out  1  one-cycle pulse: session of requester i complete
- ovf0, ovf1  out  1  valid with done_i; letters were dropped in this session
- ready_fifo  out  1  to FIFO: start session
- fifo_char  out  8  to FIFO people_thing_in
- valid_fifo, done_fifo  in  1  from FIFO
- people_thing_out  in  8  from FIFO

## Operation
- States and transitions:
  - IDLE: if any req, latch the grant and go to START.
  - START: go to WRITE.
  - WRITE: on vld_i && last_i go to TERM.
  - TERM: go to READ.
  - READ: on done_fifo go to IDLE.
- Arbitration is round-robin, decided in IDLE:
  - Single request: that requester wins.
  - Both request: the requester that was not granted last wins.
  - The last-grant pointer resets to 1, so req0 wins the first tie.
  - gnt_i is held from START through READ inclusive.
  - req is ignored outside IDLE; dropping req mid-session does not abort the session.
- START drives ready_fifo=1 for exactly one cycle; ready_fifo is 0 in all other states.
- WRITE drives fifo_char combinationally from the granted requester:
  - vld_i=0 → 8'h00, which the FIFO ignores (idle gap allowed).
  - char is 8'h24 ('$') → 8'h00. Requesters can never terminate early.
  - letter with count < MAX_LEN → char; count increments.
  - letter with count == MAX_LEN → 8'h00; ovf latch set.
  - any other non-letter → passed through unchanged; not counted (FIFO ignores it).
  - When last_i and char are valid together, the char is processed first under the rules above.
- TERM drives fifo_char = 8'h24 for one cycle. fifo_char is 8'h00 in IDLE, START and READ.
- READ:
  - rd_vld_i = gnt_i && valid_fifo.
  - On done_fifo: done_i=1 and ovf_i = ovf latch in the same cycle, then go to IDLE.
- count (4-bit) and the ovf latch clear in START.
- Zero-letter session: READ sees done_fifo on its first cycle; no rd_vld is asserted.

## Timing
- Reset value of every output is 0 / 8'h00; state IDLE; count 0; ovf latch 0; last-grant pointer 1.
- rst asserted mid-session aborts immediately: all outputs 0 on the next cycle, no done pulse.
- Request at cycle T, in IDLE:
  - gnt and ready_fifo at T+1.
  - FIFO enters W_DATA, controller enters WRITE (take_i=1) at T+2.
- last accepted at cycle L:
  - '$' at L+1.
  - READ from L+2.
  - k letters give k rd_vld cycles, then a done cycle D = L+2+k.
  - IDLE at D+1; next grant at D+2 at the earliest.
- Session length = 1 (START) + n (WRITE) + 1 (TERM) + k+1 (READ) cycles.
- rd_data, rd_vld, done and fifo_char are combinational from state and inputs. There is no added latency; the requester samples them on the same edge.
- done_i and rd_vld_i are never high together, because valid_fifo and done_fifo are mutually exclusive.

## Test plan
- Single session: req0 sends "AB1C" (four cycles), last on 'C' → gnt0 from T+1; fifo_char sequence A,B,8'h31,C,8'h24; rd_vld0 on three cycles with rd_data 'A','B','C'; done0 pulse with ovf0=0; gnt0 drops.
- Tie and round-robin: req0 and req1 both held high from reset → sessions granted in order 0,1,0; gnt never overlaps; rd_vld1 is asserted only in requester 1's session.
- Overflow: req1 sends 17 'Z' → fifo_char carries exactly 15 'Z'; the remaining two cycles drive 8'h00; 15 rd_vld1 cycles; done1 with ovf1=1. The next session reports ovf1=0.
- Sanitise and gaps: stream "A", gap, "$", "B"(last), with vld low for 3 cycles mid-stream → the user '$' becomes 8'h00; read-back is exactly "AB"; take0 stays high across the gaps.
- Empty session: vld0 and last0 on '5' as the first char → no rd_vld; done0 on the first READ cycle; IDLE on the next cycle.
- Reset mid-READ after 2 of 5 letters → next cycle: all outputs 0, state IDLE, no done pulse. A new req0 session then completes normally with correct data.

Source files
------------

// File: rtl/fifo_session_ctrl_if.sv
// Requester, read-back and FIFO handshake bundle for fifo_session_ctrl.
// The slave modport is the controller; master is the requesters plus FIFO.
interface fifo_session_ctrl_if;
  logic       req0, req1;
  logic       vld0, vld1;
  logic       last0, last1;
  logic [7:0] char0, char1;
  logic       gnt0, gnt1;
  logic       take0, take1;
  logic [7:0] rd_data;
  logic       rd_vld0, rd_vld1;
  logic       done0, done1;
  logic       ovf0, ovf1;
  logic       ready_fifo;
  logic [7:0] fifo_char;
  logic       valid_fifo, done_fifo;
  logic [7:0] people_thing_out;

  modport slave (
    input  req0, req1, vld0, vld1, last0, last1, char0, char1,
    input  valid_fifo, done_fifo, people_thing_out,
    output gnt0, gnt1, take0, take1, rd_data, rd_vld0, rd_vld1,
    output done0, done1, ovf0, ovf1, ready_fifo, fifo_char
  );

  modport master (
    output req0, req1, vld0, vld1, last0, last1, char0, char1,
    output valid_fifo, done_fifo, people_thing_out,
    input  gnt0, gnt1, take0, take1, rd_data, rd_vld0, rd_vld1,
    input  done0, done1, ovf0, ovf1, ready_fifo, fifo_char
  );
endinterface

// File: rtl/fifo_session_ctrl.sv
// Round-robin session arbiter that sequences the letter FIFO handshake
// (start, write, terminate, read back) and sanitises the write stream.
module fifo_session_ctrl #(
  parameter int MAX_LEN = 15
) (
  input  logic               clk,
  input  logic               rst,
  fifo_session_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] TERM  = 3'd3;
  localparam logic [2:0] READ  = 3'd4;

  localparam logic [3:0] MAX_CNT = 4'(MAX_LEN);
  localparam logic [7:0] TERM_CHAR = 8'h24;

  logic [2:0] state_reg, state_next;
  logic       sel_reg, sel_next;
  logic       last_gnt_reg, last_gnt_next;
  logic [3:0] count_reg, count_next;
  logic       ovf_reg, ovf_next;
  logic [7:0] fifo_char_next;

  logic [1:0] req_v, vld_v, last_v;
  logic       cur_vld, cur_last, cur_letter, winner;
  logic [7:0] cur_char;

  assign req_v  = {bus.req1, bus.req0};
  assign vld_v  = {bus.vld1, bus.vld0};
  assign last_v = {bus.last1, bus.last0};

  assign cur_vld    = vld_v[sel_reg];
  assign cur_last   = last_v[sel_reg];
  assign cur_char   = sel_reg ? bus.char1 : bus.char0;
  assign cur_letter = (cur_char >= 8'h41) && (cur_char <= 8'h5A);

  // On a tie the requester that was not served last wins.
  assign winner = (&req_v) ? ~last_gnt_reg : req_v[1];

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    last_gnt_next  = last_gnt_reg;
    count_next     = count_reg;
    ovf_next       = ovf_reg;
    fifo_char_next = 8'h00;
    case (state_reg)
      IDLE: begin
        if (|req_v) begin
          sel_next      = winner;
          last_gnt_next = winner;
          state_next    = START;
        end
      end
      START: begin
        count_next = 4'd0;
        ovf_next   = 1'b0;
        state_next = WRITE;
      end
      WRITE: begin
        if (cur_vld) begin
          // A user '$' is blanked so only TERM can close the write phase.
          if (cur_char == TERM_CHAR) begin
            fifo_char_next = 8'h00;
          end else if (cur_letter) begin
            if (count_reg < MAX_CNT) begin
              fifo_char_next = cur_char;
              count_next     = count_reg + 4'd1;
            end else begin
              ovf_next = 1'b1;
            end
          end else begin
            fifo_char_next = cur_char;
          end
          if (cur_last) begin
            state_next = TERM;
          end
        end
      end
      TERM: begin
        fifo_char_next = TERM_CHAR;
        state_next     = READ;
      end
      READ: begin
        if (bus.done_fifo) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sel_reg      <= 1'b0;
      last_gnt_reg <= 1'b1;
      count_reg    <= 4'd0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      last_gnt_reg <= last_gnt_next;
      count_reg    <= count_next;
      ovf_reg      <= ovf_next;
    end
  end

  logic       in_session, in_write, in_read;
  logic [1:0] gnt_v, take_v, rd_vld_v, done_v, ovf_v;

  assign in_session = (state_reg != IDLE);
  assign in_write   = (state_reg == WRITE);
  assign in_read    = (state_reg == READ);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign gnt_v[gi]    = in_session && (sel_reg == 1'(gi));
      assign take_v[gi]   = gnt_v[gi] && in_write;
      assign rd_vld_v[gi] = gnt_v[gi] && in_read && bus.valid_fifo;
      assign done_v[gi]   = gnt_v[gi] && in_read && bus.done_fifo;
      assign ovf_v[gi]    = done_v[gi] && ovf_reg;
    end
  endgenerate

  assign bus.gnt0       = gnt_v[0];
  assign bus.gnt1       = gnt_v[1];
  assign bus.take0      = take_v[0];
  assign bus.take1      = take_v[1];
  assign bus.rd_vld0    = rd_vld_v[0];
  assign bus.rd_vld1    = rd_vld_v[1];
  assign bus.done0      = done_v[0];
  assign bus.done1      = done_v[1];
  assign bus.ovf0       = ovf_v[0];
  assign bus.ovf1       = ovf_v[1];
  assign bus.rd_data    = in_read ? bus.people_thing_out : 8'h00;
  assign bus.ready_fifo = (state_reg == START);
  assign bus.fifo_char  = fifo_char_next;
endmodule
